freq_generator: RTL and testbench
=================================

// Module: freq_generator
// PURPOSE
//  Square-wave synthesiser: drives a Pmod output pin at a programmed frequency in Hz,
//  derived from the 100 MHz board clock with no residual drift (fractional accumulator).
//  Counterpart of the 1 s-gate frequency counter: looped back into it, the counter reads freq_hz.
//  New frequencies load via a strobe/busy handshake and take effect glitch-free.
// PARAMETERS
//  CLK_HZ   100_000_000  input clock rate in Hz; the test bench overrides it to 1000
//  FREQ_W   16           width of the frequency word (Hz); matches the counter's freq width
//  ACC_W    28           accumulator width; must hold CLK_HZ + 2*(2^FREQ_W-1)
// PORTS
//  CLK          in   1       100 MHz clock
//  RST_N        in   1       asynchronous active-low reset
//  en           in   1       1 = generate, 0 = stop after the current high phase
//  freq_hz      in   FREQ_W  requested frequency in Hz; sampled on an accepted load
//  load         in   1       single-cycle request to change frequency
//  busy         out  1       1 = a load is pending; further loads are ignored
//  active_freq  out  FREQ_W  frequency currently being generated
//  OUT          out  1       square-wave output to the Pmod pin
//  rise         out  1       optional; see CONFIGURATION
// BEHAVIOUR
//  Reset (async, RST_N=0): OUT=0, busy=0, active_freq=0, acc=0, pend=0, rise=0, state=IDLE.
//  Accumulator, per cycle when in RUN/DRAIN: sum = acc + 2*active_freq (ACC_W bits, no overflow).
//   - If sum >= CLK_HZ: acc <= sum - CLK_HZ and OUT toggles.
//   - Otherwise acc <= sum.
//   - Result: exactly 2*active_freq toggles per CLK_HZ cycles, so the average is exact.
//   - Half-periods are floor/ceil of CLK_HZ/(2f).
//  Clamp: freq_hz > CLK_HZ/2 is captured as CLK_HZ/2.
//  States:
//   - IDLE: OUT=0, acc=0. Goes to RUN when en=1 and active_freq!=0.
//   - RUN: accumulate/toggle. If en=0 and OUT=0, go to IDLE next cycle, acc cleared.
//     If en=0 and OUT=1, go to DRAIN.
//   - DRAIN: keep accumulating until OUT toggles low, then IDLE; the high phase is never truncated.
//     If en returns to 1 during DRAIN, go back to RUN with no phase discontinuity.
//   - From IDLE, the first rising edge of OUT comes ceil(CLK_HZ/(2f)) cycles after entering RUN.
//  Load handshake:
//   - load=1 with busy=0: pend <= clamp(freq_hz); busy=1 from the next cycle.
//   - load=1 with busy=1: ignored; no queue.
//   - Apply, in IDLE or with active_freq==0: next cycle after capture. active_freq<=pend, acc<=0, busy<=0.
//   - Apply, in RUN/DRAIN: on the cycle OUT toggles 0->1. active_freq<=pend, acc<=0
//     (new period starts cleanly), busy<=0. The apply and the toggle happen in the same cycle.
//   - Loading 0 stops output by the normal path: after the apply the state drops to IDLE with OUT=0.
//  Simultaneous events:
//   - load and apply in the same cycle cannot happen, because busy blocks the load.
//   - en falling on a toggle cycle: the toggle happens first, then the state rules use the new OUT.
// CONFIGURATION
//  FREQ_GEN_RISE_EN defined:
//   - rise = 1 for exactly one cycle, the cycle after OUT goes 0->1 (registered).
//   - Reset value 0.
//   - Intended as a sync strobe for scope triggering or the display.
//  Not defined:
//   - rise is tied to 0.
//   - No extra registers are synthesised; the port remains for pinout stability.
// TESTING (CLK_HZ=1000 unless stated)
//  1. load f=1, en=1 -> OUT high for cycles 500-999, low for 1000-1499; exactly 1 rise per 1000 cycles.
//  2. load f=3 -> 3 rising edges per 1000 cycles, half-periods only 166/167; no drift over 10 s.
//  3. Running at f=1, load f=2 at cycle 200, then load f=5 while busy=1
//      -> f=5 ignored; busy clears at the next rise; active_freq=2; acc=0.
//  4. en=0 mid high phase -> OUT completes the full 500-cycle high, then IDLE with OUT=0;
//      en=0 while OUT low -> IDLE next cycle.
//  5. RST_N pulsed low while OUT=1 -> OUT, busy, active_freq = 0 immediately (async, no clock edge).
//  6. CLK_HZ=100_000_000, f=12345, looped into the 1 s frequency counter -> counter reads 12345.

Source files
------------

// File: rtl/freq_generator.sv
// freq_generator: square-wave synthesiser driven by a fractional accumulator, with a
// strobe/busy frequency-load handshake. Define FREQ_GEN_RISE_EN to enable the rise strobe.
module freq_generator #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned FREQ_W = 16,
  parameter int unsigned ACC_W  = 28
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              en,
  input  logic [FREQ_W-1:0] freq_hz,
  input  logic              load,
  output logic              busy,
  output logic [FREQ_W-1:0] active_freq,
  output logic              OUT,
  output logic              rise
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] HALF_HZ = ACC_W'(CLK_HZ / 32'd2);

  // Requests above Nyquist are pinned to one toggle per clock.
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f);
    logic [ACC_W-1:0] f_ext;
    f_ext = ACC_W'(f);
    if (f_ext > HALF_HZ) begin
      clamp_freq = FREQ_W'(HALF_HZ);
    end else begin
      clamp_freq = f;
    end
  endfunction

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              out_q, out_d;
  logic [FREQ_W-1:0] active_q, active_d;
  logic [FREQ_W-1:0] pend_q, pend_d;
  logic              busy_q, busy_d;

  logic [ACC_W-1:0]  sum;
  logic              running;
  logic              toggle;
  logic              out_nxt;
  logic              rise_edge;
  logic              act_zero;
  logic              accept;
  logic              apply;

  always_comb begin
    running   = (state_q == S_RUN) || (state_q == S_DRAIN);
    sum       = acc_q + (ACC_W'(active_q) << 1);
    toggle    = running && (sum >= CLK_LIM);
    out_nxt   = toggle ? ~out_q : out_q;
    rise_edge = toggle && !out_q;
    act_zero  = (active_q == {FREQ_W{1'b0}});
    accept    = load && !busy_q;
    // A pending word lands immediately when idle, otherwise only at a rising edge.
    apply     = busy_q && ((state_q == S_IDLE) || act_zero || rise_edge);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The state rules look at the post-toggle level, so a falling edge ends a drain at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en && !act_zero) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (act_zero) begin
          state_d = S_IDLE;
        end else if (!en) begin
          state_d = out_nxt ? S_DRAIN : S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (act_zero) begin
          state_d = S_IDLE;
        end else if (en) begin
          state_d = S_RUN;
        end else if (!out_nxt) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (apply || (state_d == S_IDLE) || !running) begin
      acc_d = {ACC_W{1'b0}};
    end else if (toggle) begin
      acc_d = sum - CLK_LIM;
    end else begin
      acc_d = sum;
    end

    if (!running || act_zero) begin
      out_d = 1'b0;
    end else begin
      out_d = out_nxt;
    end

    active_d = apply ? pend_q : active_q;
    pend_d   = accept ? clamp_freq(freq_hz) : pend_q;

    if (accept) begin
      busy_d = 1'b1;
    end else if (apply) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q    <= {ACC_W{1'b0}};
      out_q    <= 1'b0;
      active_q <= {FREQ_W{1'b0}};
      pend_q   <= {FREQ_W{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      out_q    <= out_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
    end
  end

`ifdef FREQ_GEN_RISE_EN
  logic rise_q;

  // Strobe is high during the first cycle of every high phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= rise_edge;
    end
  end

  assign rise = rise_q;
`else
  assign rise = 1'b0;
`endif

  assign busy        = busy_q;
  assign active_freq = active_q;
  assign OUT         = out_q;

endmodule

// File: tb/tb_freq_generator.sv
// Bench for freq_generator at CLK_HZ=1000: table-driven frequency sweeps, hand-written
// corner sequences and randomised runs against a closed-form phase model.
module tb_freq_generator;
  localparam int CLK_HZ = 1000;
  localparam int FREQ_W = 16;
  localparam int ACC_W  = 28;

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b1;
  logic              en    = 1'b0;
  logic              load  = 1'b0;
  logic [FREQ_W-1:0] freq_hz = 16'd0;
  logic              busy;
  logic [FREQ_W-1:0] active_freq;
  logic              OUT;
  logic              rise;

  freq_generator #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W), .ACC_W(ACC_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .freq_hz(freq_hz), .load(load),
    .busy(busy), .active_freq(active_freq), .OUT(OUT), .rise(rise)
  );

  always #5 CLK = ~CLK;

  int     errors = 0;
  int     checks = 0;
  longint cyc    = 0;

  // Reference model: one phase segment (start cycle, frequency, starting level) at a time.
  bit     m_running, m_out, m_busy, m_rise;
  int     m_active, m_pend;
  longint seg_ts;
  int     seg_f;
  bit     seg_o;

  typedef struct {
    int f; int act; int rises; int min_h; int max_h; int first;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp(input int f);
    return (f > CLK_HZ / 2) ? CLK_HZ / 2 : f;
  endfunction

  // Level after (t - seg_ts) accumulations: toggles so far = floor(2*f*k / CLK_HZ).
  function automatic bit seg_level(input longint t);
    longint n;
    n = (2 * longint'(seg_f) * (t - seg_ts)) / CLK_HZ;
    return seg_o ^ bit'(n % 2);
  endfunction

  task automatic model_edge();
    bit e, rising, was_busy, prev;
    int act_old;
    was_busy = m_busy;
    act_old  = m_active;
    prev     = m_out;
    if (m_running) begin
      e      = seg_level(cyc);
      rising = e && !prev;
      if (was_busy && (act_old == 0 || rising)) begin
        m_active = m_pend;
        m_busy   = 1'b0;
        if (rising) begin
          seg_ts = cyc; seg_f = m_pend; seg_o = 1'b1;
        end
      end
      if (act_old == 0) begin
        m_running = 1'b0; e = 1'b0;
      end else if (!en && !e) begin
        m_running = 1'b0;
      end
      m_out = e;
    end else begin
      m_out = 1'b0;
      if (was_busy) begin
        m_active = m_pend; m_busy = 1'b0;
      end
      if (en && act_old != 0) begin
        m_running = 1'b1; seg_ts = cyc; seg_f = m_active; seg_o = 1'b0;
      end
    end
    m_rise = m_out && !prev;
    if (load && !was_busy) begin
      m_pend = clamp(int'(freq_hz));
      m_busy = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    #1;
    model_edge();
    check("OUT", OUT, m_out);
    check("busy", busy, m_busy);
    check("active_freq", active_freq, m_active);
`ifdef FREQ_GEN_RISE_EN
    check("rise", rise, m_rise);
`else
    check("rise_tied", rise, 0);
`endif
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load_pulse(input int f);
    load = 1'b1;
    freq_hz = 16'(f);
    step();
    load = 1'b0;
  endtask

  // Reset is asserted and checked between clock edges to show it is asynchronous.
  task automatic do_reset();
    en = 1'b0;
    load = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("rst_OUT", OUT, 0);
    check("rst_busy", busy, 0);
    check("rst_active", active_freq, 0);
    check("rst_rise", rise, 0);
    m_running = 1'b0; m_out = 1'b0; m_busy = 1'b0; m_rise = 1'b0;
    m_active = 0; m_pend = 0;
    #3 RST_N = 1'b1;
  endtask

  // Load with en already high; returns once the RUN segment has just started.
  task automatic start_run(input int f);
    en = 1'b1;
    load_pulse(f);
    run(2);
  endtask

  initial begin
    int rises, min_h, max_h, first, ntog;
    longint last_tog;
    bit prev;

    tbl[0] = '{1,     1,   1,   500, 500, 500};
    tbl[1] = '{3,     3,   3,   166, 167, 167};
    tbl[2] = '{7,     7,   7,   71,  72,  72};
    tbl[3] = '{250,   250, 250, 2,   2,   2};
    tbl[4] = '{333,   333, 333, 1,   2,   2};
    tbl[5] = '{500,   500, 500, 1,   1,   1};
    tbl[6] = '{501,   500, 500, 1,   1,   1};
    tbl[7] = '{65535, 500, 500, 1,   1,   1};
    tbl[8] = '{0,     0,   0,   0,   0,   0};

    do_reset();
    run(3);

    // Sweep: one second of output measured from RUN entry
    for (int i = 0; i < 9; i++) begin
      do_reset();
      start_run(tbl[i].f);
      rises = 0; first = 0; ntog = 0; min_h = 1000000; max_h = 0;
      last_tog = 0; prev = 1'b0;
      for (int k = 1; k <= CLK_HZ; k++) begin
        step();
        if (OUT != prev) begin
          if (ntog > 0) begin
            if (k - last_tog < min_h) min_h = int'(k - last_tog);
            if (k - last_tog > max_h) max_h = int'(k - last_tog);
          end
          ntog++;
          last_tog = k;
          if (OUT) begin
            rises++;
            if (first == 0) first = k;
          end
        end
        prev = OUT;
      end
      if (ntog < 2) begin
        min_h = 0; max_h = 0;
      end
      check("tbl_active", active_freq, tbl[i].act);
      check("tbl_rises", rises, tbl[i].rises);
      check("tbl_min_half", min_h, tbl[i].min_h);
      check("tbl_max_half", max_h, tbl[i].max_h);
      check("tbl_first_rise", first, tbl[i].first);
    end

    // Reload while running, second load ignored while busy
    do_reset();
    start_run(1);
    run(200);
    load_pulse(2);
    run(5);
    check("t3_busy_held", busy, 1);
    load_pulse(5);
    run(400);
    check("t3_active", active_freq, 2);
    check("t3_busy_clear", busy, 0);
    run(600);

    // en low mid high phase: full high phase completes, then idle
    do_reset();
    start_run(1);
    run(700);
    en = 1'b0;
    run(299);
    check("t4_hold_high", OUT, 1);
    run(2);
    check("t4_drained_low", OUT, 0);
    run(600);
    // en low while OUT low: idle on the next cycle, no later rise
    en = 1'b1;
    run(101);
    en = 1'b0;
    run(700);
    check("t4_idle_low", OUT, 0);
    // en back during drain: phase continues undisturbed
    en = 1'b1;
    run(600);
    en = 1'b0;
    run(100);
    en = 1'b1;
    run(1000);

    // Loading 0 stops the output after the next rise
    do_reset();
    start_run(3);
    run(100);
    load_pulse(0);
    run(400);
    check("t_zero_active", active_freq, 0);
    check("t_zero_out", OUT, 0);

    // Async reset while OUT high
    do_reset();
    start_run(1);
    run(600);
    check("t5_pre_high", OUT, 1);
    do_reset();
    run(5);

    // Randomised runs against the phase model
    for (int it = 0; it < 8; it++) begin
      do_reset();
      load_pulse($urandom_range(1, 520));
      run($urandom_range(1, 5));
      en = 1'b1;
      run($urandom_range(200, 1200));
      if ($urandom_range(0, 1) == 1) begin
        load_pulse($urandom_range(0, 600));
        run(3);
        load_pulse($urandom_range(1, 600));
      end
      run($urandom_range(200, 1000));
      repeat (3) begin
        en = 1'b0;
        run($urandom_range(1, 300));
        en = 1'b1;
        run($urandom_range(1, 300));
      end
      en = 1'b0;
      run(600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
